// File: rtl/switch_reader_if.sv
// Read bus between memorio and the switch/button reader.
// The master drives select, strobe and address; the slave returns registered read data.
interface switch_reader_if;
   logic        switchcs;
   logic        switchread;
   logic [1:0]  switchaddr;
   logic [15:0] switchrdata;

   modport master (output switchcs, output switchread, output switchaddr, input switchrdata);
   modport slave  (input switchcs, input switchread, input switchaddr, output switchrdata);
endinterface

// File: rtl/switch_reader.sv
// Synchronizes and debounces the board switches and the confirm button, keeps a sticky
// press flag, and returns registered read data to memorio (zero whenever not read).
module switch_reader #(
   parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
   input  logic              switch_clk,
   input  logic              switchrst,
   switch_reader_if.slave    bus,
   input  logic [15:0]       switch_i,
   input  logic              button_i
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [15:0]      sw_s1, sw_s2, sw_prev, sw_stable;
   logic [CNT_W-1:0] sw_cnt;
   logic             btn_s1, btn_s2, btn_prev, btn_stable;
   logic [CNT_W-1:0] btn_cnt;
   logic             press_flag;

   logic             sw_hold, sw_accept;
   logic             btn_hold, btn_accept, btn_rise;
   logic             rd_en, flag_clr;
   logic [15:0]      rdata_next;

   // A count only advances while the synchronized value is both new and unchanged.
   always_comb begin
      sw_hold    = (sw_s2 == sw_prev) && (sw_s2 != sw_stable);
      sw_accept  = sw_hold && (sw_cnt == CNT_LAST);
      btn_hold   = (btn_s2 == btn_prev) && (btn_s2 != btn_stable);
      btn_accept = btn_hold && (btn_cnt == CNT_LAST);
      btn_rise   = btn_accept && btn_s2;
      rd_en      = bus.switchcs && bus.switchread;
      flag_clr   = rd_en && (bus.switchaddr == 2'b11);
      rdata_next = 16'h0000;
      if (rd_en) begin
         case (bus.switchaddr)
            2'b00:   rdata_next = {8'h00, sw_stable[7:0]};
            2'b10:   rdata_next = {8'h00, sw_stable[15:8]};
            2'b01:   rdata_next = sw_stable;
            default: rdata_next = {15'b0, press_flag};
         endcase
      end
   end

   always_ff @(posedge switch_clk or posedge switchrst) begin
      if (switchrst) begin
         sw_s1           <= 16'h0000;
         sw_s2           <= 16'h0000;
         sw_prev         <= 16'h0000;
         sw_stable       <= 16'h0000;
         sw_cnt          <= '0;
         btn_s1          <= 1'b0;
         btn_s2          <= 1'b0;
         btn_prev        <= 1'b0;
         btn_stable      <= 1'b0;
         btn_cnt         <= '0;
         press_flag      <= 1'b0;
         bus.switchrdata <= 16'h0000;
      end else begin
         sw_s1    <= switch_i;
         sw_s2    <= sw_s1;
         sw_prev  <= sw_s2;
         btn_s1   <= button_i;
         btn_s2   <= btn_s1;
         btn_prev <= btn_s2;

         if (!sw_hold) begin
            sw_cnt <= '0;
         end else if (sw_accept) begin
            sw_cnt    <= '0;
            sw_stable <= sw_s2;
         end else begin
            sw_cnt <= sw_cnt + CNT_W'(1);
         end

         if (!btn_hold) begin
            btn_cnt <= '0;
         end else if (btn_accept) begin
            btn_cnt    <= '0;
            btn_stable <= btn_s2;
         end else begin
            btn_cnt <= btn_cnt + CNT_W'(1);
         end

         // A press landing on the same edge as a clearing read must not be lost.
         if (btn_rise) begin
            press_flag <= 1'b1;
         end else if (flag_clr) begin
            press_flag <= 1'b0;
         end

         bus.switchrdata <= rdata_next;
      end
   end

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with DEBOUNCE_CYCLES=4: a vector table for the basic
// read path plus hand-written sequences for bounce, press-flag and reset corner cases.
module tb_switch_reader;

   logic        clk;
   logic        rst;
   logic [15:0] sw;
   logic        btn;
   int          n_checks;
   int          n_fail;

   switch_reader_if bus ();

   switch_reader #(.DEBOUNCE_CYCLES(4)) dut (
      .switch_clk (clk),
      .switchrst  (rst),
      .bus        (bus.slave),
      .switch_i   (sw),
      .button_i   (btn)
   );

   typedef struct {
      logic        cs;
      logic        rd;
      logic [1:0]  addr;
      logic [15:0] sw;
      logic        btn;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [15];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic rd, input logic [1:0] addr);
      bus.switchcs   = cs;
      bus.switchread = rd;
      bus.switchaddr = addr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_rdata", bus.switchrdata, 16'h0000);
      step();
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      sw       = 16'h0000;
      btn      = 1'b0;
      drive(1'b0, 1'b0, 2'b00);

      for (int i = 0; i < 7; i++)  tbl[i] = '{1'b1, 1'b1, 2'b01, 16'hA55A, 1'b0, 16'h0000};
      for (int i = 7; i < 10; i++) tbl[i] = '{1'b1, 1'b1, 2'b01, 16'hA55A, 1'b0, 16'hA55A};
      tbl[10] = '{1'b1, 1'b1, 2'b00, 16'hA55A, 1'b0, 16'h005A};
      tbl[11] = '{1'b1, 1'b1, 2'b10, 16'hA55A, 1'b0, 16'h00A5};
      tbl[12] = '{1'b1, 1'b0, 2'b01, 16'hA55A, 1'b0, 16'h0000};
      tbl[13] = '{1'b0, 1'b1, 2'b01, 16'hA55A, 1'b0, 16'h0000};
      tbl[14] = '{1'b1, 1'b1, 2'b11, 16'hA55A, 1'b0, 16'h0000};

      step();
      do_reset();

      // Clean change to A55A at edge 0, then byte/halfword/no-read mapping.
      for (int i = 0; i < 15; i++) begin
         sw  = tbl[i].sw;
         btn = tbl[i].btn;
         drive(tbl[i].cs, tbl[i].rd, tbl[i].addr);
         step();
         check($sformatf("table_%0d", i), bus.switchrdata, tbl[i].exp);
      end

      // Bouncing input never accepted; final hold accepted 6 edges later.
      drive(1'b0, 1'b0, 2'b00);
      sw = 16'h0000;
      do_reset();
      drive(1'b1, 1'b1, 2'b01);
      for (int c = 0; c < 20; c++) begin
         sw = (((c / 2) % 2) == 0) ? 16'h00FF : 16'h0000;
         step();
         check("bounce_hold_zero", bus.switchrdata, 16'h0000);
      end
      sw = 16'h00FF;
      for (int j = 0; j < 8; j++) begin
         step();
         check($sformatf("bounce_settle_%0d", j), bus.switchrdata, (j < 7) ? 16'h0000 : 16'h00FF);
      end
      drive(1'b1, 1'b1, 2'b00);
      step();
      check("bounce_low_byte", bus.switchrdata, 16'h00FF);
      drive(1'b1, 1'b1, 2'b10);
      step();
      check("bounce_high_byte", bus.switchrdata, 16'h0000);

      // Button pulse sets the flag; selected-but-not-read leaves it alone; read clears.
      drive(1'b0, 1'b0, 2'b00);
      do_reset();
      btn = 1'b1;
      for (int j = 0; j < 10; j++) step();
      btn = 1'b0;
      drive(1'b1, 1'b0, 2'b11);
      for (int j = 0; j < 25; j++) begin
         step();
         check("cs_no_read_zero", bus.switchrdata, 16'h0000);
      end
      drive(1'b1, 1'b1, 2'b11);
      step();
      check("press_first_read", bus.switchrdata, 16'h0001);
      step();
      check("press_second_read", bus.switchrdata, 16'h0000);

      // Clearing read coincides with btn_stable rising at edge 6: set wins.
      drive(1'b0, 1'b0, 2'b00);
      do_reset();
      btn = 1'b1;
      for (int j = 0; j < 6; j++) step();
      drive(1'b1, 1'b1, 2'b11);
      step();
      check("coincide_read", bus.switchrdata, 16'h0000);
      step();
      check("coincide_next_read", bus.switchrdata, 16'h0001);
      step();
      check("coincide_third_read", bus.switchrdata, 16'h0000);

      // Reset with flag set and button held: cleared, then set again after debounce.
      drive(1'b0, 1'b0, 2'b00);
      do_reset();
      for (int j = 0; j < 10; j++) step();
      do_reset();
      drive(1'b1, 1'b1, 2'b11);
      step();
      check("flag_after_reset", bus.switchrdata, 16'h0000);
      drive(1'b0, 1'b0, 2'b00);
      for (int j = 1; j < 7; j++) step();
      drive(1'b1, 1'b1, 2'b11);
      step();
      check("flag_reaccepted", bus.switchrdata, 16'h0001);
      btn = 1'b0;

      // Reset pulse mid-count discards the pending 1234 and restarts the full latency.
      drive(1'b0, 1'b0, 2'b00);
      do_reset();
      sw = 16'h0F0F;
      drive(1'b1, 1'b1, 2'b01);
      for (int j = 0; j < 8; j++) step();
      check("pre_reset_value", bus.switchrdata, 16'h0F0F);
      sw = 16'h1234;
      for (int j = 0; j < 3; j++) begin
         step();
         check("mid_count_old", bus.switchrdata, 16'h0F0F);
      end
      rst = 1'b1;
      #1;
      check("async_reset_rdata", bus.switchrdata, 16'h0000);
      step();
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         step();
         check($sformatf("post_reset_%0d", j), bus.switchrdata, (j < 7) ? 16'h0000 : 16'h1234);
      end

      drive(1'b0, 1'b0, 2'b00);
      step();
      check("idle_zero", bus.switchrdata, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000, number of consecutive cycles a new synchronized input value must hold before acceptance; legal range 2..2^20.
REQ-002 switch_clk  input  1  block clock; all state updates on its rising edge.
REQ-003 switchrst  input  1  reset; asynchronous, active-high.
REQ-004 switchcs  input  1  chip select from memorio; 1 = this block is addressed.
REQ-005 switchread  input  1  read strobe, active-high; a read occurs only when switchcs=1 and switchread=1 in the same cycle.
REQ-006 switchaddr  input  2  register select: 2'b00 low byte, 2'b10 high byte, 2'b01 full halfword, 2'b11 button status.
REQ-007 switch_i  input  16  raw board switches; asynchronous to switch_clk.
REQ-008 button_i  input  1  raw board confirm button; asynchronous, active-high.
REQ-009 switchrdata  output  16  read data returned to memorio.

Function
REQ-010 switch_i and button_i SHALL each pass through a two-flop synchronizer (s1, s2); no other logic SHALL sample the raw inputs.
REQ-011 Switch debounce SHALL hold a 16-bit accepted value sw_stable and a counter sw_cnt wide enough for DEBOUNCE_CYCLES-1.
REQ-012 sw_cnt SHALL clear in any cycle where s2 equals sw_stable or s2 differs from its previous-cycle value.
REQ-013 Otherwise sw_cnt SHALL increment; when sw_cnt equals DEBOUNCE_CYCLES-1, sw_stable SHALL load s2 and sw_cnt SHALL clear in that cycle.
REQ-014 Consequence: a clean raw change at edge k SHALL appear in sw_stable at edge k+2+DEBOUNCE_CYCLES; any bounce inside that window restarts the count.
REQ-015 The button SHALL use an identical, independent 1-bit debouncer producing btn_stable with its own counter.
REQ-016 A 0->1 transition of btn_stable SHALL set a sticky press_flag; 1->0 transitions SHALL have no effect on it.
REQ-017 A read with switchaddr=2'b11 SHALL clear press_flag at the same edge that captures the read data; the captured data SHALL carry the pre-clear value.
REQ-018 If a btn_stable rising edge and a clearing read coincide, press_flag SHALL end at 1 (set wins) and the read data SHALL report the pre-edge value.
REQ-019 switchrdata SHALL be registered, updating one cycle after the read cycle (latency 1).
REQ-020 Read data mapping: 2'b00 -> {8'h00, sw_stable[7:0]}; 2'b10 -> {8'h00, sw_stable[15:8]}; 2'b01 -> sw_stable; 2'b11 -> {15'b0, press_flag}.
REQ-021 In any cycle with no read (switchcs=0 or switchread=0), switchrdata SHALL load 16'h0000 at the next edge, so memorio can OR-merge peripheral buses.
REQ-022 Reads SHALL have no side effects other than REQ-017; back-to-back reads on consecutive cycles SHALL each return data one cycle later.
REQ-023 Counters SHALL never wrap: the accept condition at DEBOUNCE_CYCLES-1 always fires before overflow.

Reset
REQ-024 While switchrst=1: s1, s2 (both paths), sw_stable=16'h0000, btn_stable=0, sw_cnt=0, btn_cnt=0, press_flag=0, switchrdata=16'h0000, independent of switch_clk.
REQ-025 Reset asserted mid-debounce SHALL discard the pending count; after release, a held raw input SHALL be re-accepted after the full REQ-014 latency measured from the first edge after release.
REQ-026 Reset asserted with press_flag=1 SHALL clear it; a button still held across release SHALL set press_flag after debounce (btn_stable rises from its reset value of 0).

Verification (DEBOUNCE_CYCLES=4)
REQ-027 switch_i 0->16'hA55A at edge 0, held; read addr 2'b01 each cycle -> switchrdata 16'h0000 until sw_stable updates at edge 6, first 16'hA55A one cycle later.
REQ-028 switch_i toggles 16'h00FF/16'h0000 every 2 cycles for 20 cycles, then holds 16'h00FF -> sw_stable stays 0 during toggling, becomes 16'h00FF 6 edges after final change; addr 2'b00 returns 16'h00FF, addr 2'b10 returns 16'h0000.
REQ-029 button_i pulsed high 10 cycles -> press_flag=1; read 2'b11 returns 16'h0001, immediate second read returns 16'h0000.
REQ-030 Clearing read issued in the exact cycle btn_stable rises -> that read returns 16'h0000, next read returns 16'h0001.
REQ-031 switchrst asserted for 1 cycle mid-count with switch_i=16'h1234 held -> outputs 0 immediately; 16'h1234 accepted 6 edges after release.
REQ-032 switchcs=1, switchread=0 for many cycles with press_flag=1 -> switchrdata stays 16'h0000 and press_flag remains 1.
